countdown_timer_core: RTL and testbench
=======================================

// Module: countdown_timer_core
// PURPOSE
//  Countdown engine for the clock. It holds a minutes:seconds value (0:00..3:59) and decrements it once per second.
//  It produces Qm[1:0] and Qs[5:0] in binary, plus a 1 Hz strobe; these feed the downstream 7-seg encoder stage directly.
//  The block has start/pause, load-preset and clear controls, and a sticky Done flag when 0:00 is reached.
// PARAMETERS
//  TICK_DIV   50_000_000  CLK cycles per 1 s tick (>=2; benches use 4)
//  MAX_SEC    59          largest seconds value; seconds wrap target
// PORTS
//  CLK        in   1  system clock, single clock domain
//  RST_n      in   1  asynchronous, active-low reset
//  StartStop  in   1  synchronous level; a rising edge toggles run/pause
//  Load       in   1  synchronous level; while high, loads the preset (ignored in RUN)
//  Clear      in   1  synchronous level; while high, forces IDLE and 0:00
//  PresetM    in   2  preset minutes 0..3
//  PresetS    in   6  preset seconds; values >59 clamp to 59
//  Qm         out  2  current minutes (binary)
//  Qs         out  6  current seconds (binary, 0..59)
//  Tick1Hz    out  1  one-CLK pulse coincident with every Qm/Qs decrement
//  Running    out  1  high in state RUN only
//  Done       out  1  high in state DONE only
// BEHAVIOUR
//  Reset (RST_n=0, async): state=IDLE; Qm=0, Qs=0; Tick1Hz, Running, Done = 0; prescaler=0; StartStop edge history=0.
//  Edge detect: ss_q <= StartStop each cycle. ss_rise = StartStop & ~ss_q. A level held high gives exactly one event.
//  Priority per cycle: Clear > Load > ss_rise > tick.
//  States:
//   IDLE : Load -> Qm=PresetM, Qs=min(PresetS,59), prescaler=0, stay IDLE.
//          ss_rise -> RUN if {Qm,Qs}!=0, otherwise DONE. The prescaler restarts at 0.
//   RUN  : prescaler counts 0..TICK_DIV-1.
//          At terminal count (TCNT), on the next edge: prescaler=0, Tick1Hz=1, and the count decrements:
//           Qs!=0 -> Qs-1;
//           Qs==0 -> Qs=MAX_SEC, Qm-1.
//          If the decremented value is 0:00, the same edge enters DONE.
//          ss_rise -> PAUSE, with the prescaler held at its current value. ss_rise wins over a coincident TCNT: no decrement.
//          Load is ignored.
//   PAUSE: the prescaler and count hold. ss_rise -> RUN, resuming the partial second. Load -> preset, prescaler=0, IDLE.
//   DONE : Qm=Qs=0 held. Load -> preset, IDLE. ss_rise -> stays DONE, because the value is zero.
//  Clear, from any state: next edge gives IDLE, Qm=Qs=0, prescaler=0, Tick1Hz=0.
//  Latency: Load, Clear and state changes are visible one CLK after the sampling edge. Tick1Hz and the new Qm/Qs change on the same edge.
//  A decrement occurs exactly TICK_DIV cycles after entering RUN with prescaler=0. Paused time does not count.
//  Tick1Hz is never asserted outside RUN. Tick1Hz is 0 on every cycle except decrement edges.
//  Width: Qm never underflows, because DONE is entered at 0:00 before any further decrement. Qs is never >59.
//  Mid-operation reset: returns to IDLE at 0:00 immediately. No preset is retained.
// STRUCTURE
//  Shared package timer_pkg: state encodings ST_IDLE/ST_RUN/ST_PAUSE/ST_DONE (2 bits), MAX_SEC=59, MAX_MIN=3,
//  and the widths SEC_W=6, MIN_W=2. The encoder stage reuses these widths.
//  Sub-module tick_prescaler (params TICK_DIV):
//   ports CLK, RST_n, en, clr -> tc. It counts while en=1, holds while en=0, and zeroes on clr.
//  Top: the edge detector, the FSM and the min:sec down-counter.
// TESTING (TICK_DIV=4)
//  1 Reset mid-RUN at 1:05 -> Qm=0, Qs=0, Running=0, Done=0, Tick1Hz=0, all asynchronously.
//  2 Load 0:02, StartStop rise -> Tick1Hz at +4 and +8 CLK.
//    Qs goes 2->1->0; Done=1 and Running=0 on the same edge as the 2nd tick. No 3rd tick follows.
//  3 Load 1:00, run one tick -> Qm=0, Qs=59.
//    Load PresetS=63 in IDLE -> Qs=59.
//  4 Load 0:10, run 2 CLK, pause for 20 CLK, resume -> first Tick1Hz 2 CLK after resume. Qs=9.
//    Holding StartStop high 10 CLK gives one toggle only.
//  5 Clear and Load asserted in the same cycle during PAUSE -> IDLE at 0:00.
//    Load during RUN -> no change to Qm/Qs.
//  6 StartStop rise at 0:00 in IDLE -> DONE, Done=1. A following Load 3:59 -> IDLE with Qm=3, Qs=59, Done=0.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and widths for the countdown timer and its downstream 7-seg encoder stage.
package timer_pkg;

    localparam int unsigned SEC_W   = 6;
    localparam int unsigned MIN_W   = 2;
    localparam int unsigned MAX_SEC = 59;
    localparam int unsigned MAX_MIN = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } timer_state_t;

    function automatic logic [SEC_W-1:0] clamp_sec(input logic [SEC_W-1:0] s,
                                                   input int unsigned        max_s);
        if (int'(s) > int'(max_s))
            return SEC_W'(max_s);
        return s;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides CLK down to a one-second terminal-count flag; holds while disabled, zeroes on clr.
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic CLK,
    input  logic RST_n,
    input  logic en,
    input  logic clr,
    output logic tc
);

    localparam int unsigned CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + CW'(1);
    end

    assign tc = (cnt == CW'(TICK_DIV - 1));

endmodule

// File: rtl/countdown_timer_core.sv
// Minutes:seconds countdown engine: StartStop edge detect, run/pause/done FSM and min:sec down-counter.
module countdown_timer_core
    import timer_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter int unsigned MAX_SEC  = timer_pkg::MAX_SEC
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic             StartStop,
    input  logic             Load,
    input  logic             Clear,
    input  logic [MIN_W-1:0] PresetM,
    input  logic [SEC_W-1:0] PresetS,
    output logic [MIN_W-1:0] Qm,
    output logic [SEC_W-1:0] Qs,
    output logic             Tick1Hz,
    output logic             Running,
    output logic             Done
);

    timer_state_t state;
    logic         ss_q;
    logic         ss_rise;
    logic         tc;
    logic         ps_en;
    logic         ps_clr;

    assign ss_rise = StartStop & ~ss_q;

    // The prescaler only advances in RUN; a coincident ss_rise pauses it before it can wrap.
    assign ps_en  = (state == ST_RUN) & ~ss_rise;
    assign ps_clr = Clear
                  | (state == ST_IDLE) | (state == ST_DONE)
                  | ((state == ST_PAUSE) & Load)
                  | ((state == ST_RUN) & tc & ~ss_rise);

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .CLK  (CLK),
        .RST_n(RST_n),
        .en   (ps_en),
        .clr  (ps_clr),
        .tc   (tc)
    );

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n)
            ss_q <= 1'b0;
        else
            ss_q <= StartStop;
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        timer_state_t nxt;
        if (!RST_n) begin
            state   <= ST_IDLE;
            Qm      <= '0;
            Qs      <= '0;
            Tick1Hz <= 1'b0;
            Running <= 1'b0;
            Done    <= 1'b0;
        end else begin
            nxt     = state;
            Tick1Hz <= 1'b0;
            if (Clear) begin
                nxt = ST_IDLE;
                Qm  <= '0;
                Qs  <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (Load) begin
                            Qm <= PresetM;
                            Qs <= clamp_sec(PresetS, MAX_SEC);
                        end else if (ss_rise) begin
                            nxt = ({Qm, Qs} != '0) ? ST_RUN : ST_DONE;
                        end
                    end
                    ST_RUN: begin
                        if (ss_rise) begin
                            nxt = ST_PAUSE;
                        end else if (tc) begin
                            Tick1Hz <= 1'b1;
                            if (Qs != '0) begin
                                Qs <= Qs - SEC_W'(1);
                                if (Qm == '0 && Qs == SEC_W'(1))
                                    nxt = ST_DONE;
                            end else begin
                                Qs <= SEC_W'(MAX_SEC);
                                Qm <= Qm - MIN_W'(1);
                            end
                        end
                    end
                    ST_PAUSE: begin
                        if (Load) begin
                            Qm  <= PresetM;
                            Qs  <= clamp_sec(PresetS, MAX_SEC);
                            nxt = ST_IDLE;
                        end else if (ss_rise) begin
                            nxt = ST_RUN;
                        end
                    end
                    ST_DONE: begin
                        if (Load) begin
                            Qm  <= PresetM;
                            Qs  <= clamp_sec(PresetS, MAX_SEC);
                            nxt = ST_IDLE;
                        end
                    end
                    default: nxt = ST_IDLE;
                endcase
            end
            state   <= nxt;
            Running <= (nxt == ST_RUN);
            Done    <= (nxt == ST_DONE);
        end
    end

endmodule

// File: tb/tb_countdown_timer_core.sv
// Directed bench for countdown_timer_core with TICK_DIV=4.
module tb_countdown_timer_core;

    logic       CLK = 1'b0;
    logic       RST_n = 1'b0;
    logic       StartStop = 1'b0;
    logic       Load = 1'b0;
    logic       Clear = 1'b0;
    logic [1:0] PresetM = '0;
    logic [5:0] PresetS = '0;
    logic [1:0] Qm;
    logic [5:0] Qs;
    logic       Tick1Hz;
    logic       Running;
    logic       Done;

    int n_cmp = 0;
    int n_err = 0;

    countdown_timer_core #(.TICK_DIV(4), .MAX_SEC(59)) dut (
        .CLK      (CLK),
        .RST_n    (RST_n),
        .StartStop(StartStop),
        .Load     (Load),
        .Clear    (Clear),
        .PresetM  (PresetM),
        .PresetS  (PresetS),
        .Qm       (Qm),
        .Qs       (Qs),
        .Tick1Hz  (Tick1Hz),
        .Running  (Running),
        .Done     (Done)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_load(input logic [1:0] m, input logic [5:0] s);
        PresetM = m;
        PresetS = s;
        Load = 1'b1;
        step();
        Load = 1'b0;
    endtask

    task automatic press();
        StartStop = 1'b1;
        step();
        StartStop = 1'b0;
    endtask

    task automatic do_clear();
        Clear = 1'b1;
        step();
        Clear = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if ({Qm, Qs, Tick1Hz, Running, Done} !== 11'd0) begin
            n_err++;
            $display("FAIL reset_init: got Qm=%0d Qs=%0d T=%b R=%b D=%b, want all 0", Qm, Qs, Tick1Hz, Running, Done);
        end
        step();
        RST_n = 1'b1;
        step();
        // Load 1:05, run to first tick, then reset mid-cycle.
        do_load(2'd1, 6'd5);
        press();
        repeat (4) step();
        n_cmp++;
        if (Tick1Hz !== 1'b1 || Qs !== 6'd4 || Running !== 1'b1) begin
            n_err++;
            $display("FAIL reset_pre_tick: got T=%b Qs=%0d R=%b, want T=1 Qs=4 R=1", Tick1Hz, Qs, Running);
        end
        #2;
        RST_n = 1'b0;
        #1;
        n_cmp++;
        if ({Qm, Qs, Tick1Hz, Running, Done} !== 11'd0) begin
            n_err++;
            $display("FAIL reset_async: got Qm=%0d Qs=%0d T=%b R=%b D=%b, want all 0", Qm, Qs, Tick1Hz, Running, Done);
        end
        step();
        RST_n = 1'b1;
        step();
        n_cmp++;
        if ({Qm, Qs, Running, Done} !== 10'd0) begin
            n_err++;
            $display("FAIL reset_no_preset: got Qm=%0d Qs=%0d R=%b D=%b, want 0:00 idle", Qm, Qs, Running, Done);
        end
    endtask

    task automatic test_countdown_done();
        do_clear();
        do_load(2'd0, 6'd2);
        press();
        for (int i = 1; i <= 16; i++) begin
            step();
            if (i == 4) begin
                n_cmp++;
                if (Tick1Hz !== 1'b1 || Qs !== 6'd1 || Running !== 1'b1 || Done !== 1'b0) begin
                    n_err++;
                    $display("FAIL tick1: got T=%b Qs=%0d R=%b D=%b, want 1 1 1 0", Tick1Hz, Qs, Running, Done);
                end
            end else if (i == 8) begin
                n_cmp++;
                if (Tick1Hz !== 1'b1 || Qs !== 6'd0 || Running !== 1'b0 || Done !== 1'b1) begin
                    n_err++;
                    $display("FAIL tick2_done: got T=%b Qs=%0d R=%b D=%b, want 1 0 0 1", Tick1Hz, Qs, Running, Done);
                end
            end else begin
                n_cmp++;
                if (Tick1Hz !== 1'b0) begin
                    n_err++;
                    $display("FAIL no_tick cyc%0d: got T=%b, want 0", i, Tick1Hz);
                end
            end
        end
        n_cmp++;
        if (Qm !== 2'd0 || Qs !== 6'd0 || Done !== 1'b1) begin
            n_err++;
            $display("FAIL done_hold: got %0d:%0d D=%b, want 0:0 D=1", Qm, Qs, Done);
        end
    endtask

    task automatic test_minute_borrow();
        do_clear();
        do_load(2'd1, 6'd0);
        press();
        repeat (4) step();
        n_cmp++;
        if (Qm !== 2'd0 || Qs !== 6'd59 || Tick1Hz !== 1'b1 || Running !== 1'b1) begin
            n_err++;
            $display("FAIL borrow: got %0d:%0d T=%b R=%b, want 0:59 T=1 R=1", Qm, Qs, Tick1Hz, Running);
        end
        do_clear();
        do_load(2'd2, 6'd63);
        n_cmp++;
        if (Qm !== 2'd2 || Qs !== 6'd59) begin
            n_err++;
            $display("FAIL clamp: got %0d:%0d, want 2:59", Qm, Qs);
        end
    endtask

    task automatic test_pause_resume();
        do_clear();
        do_load(2'd0, 6'd10);
        press();
        repeat (2) step();
        press();
        n_cmp++;
        if (Running !== 1'b0 || Qs !== 6'd10) begin
            n_err++;
            $display("FAIL pause_enter: got R=%b Qs=%0d, want R=0 Qs=10", Running, Qs);
        end
        for (int i = 0; i < 20; i++) begin
            step();
            n_cmp++;
            if (Tick1Hz !== 1'b0 || Qs !== 6'd10) begin
                n_err++;
                $display("FAIL pause_hold cyc%0d: got T=%b Qs=%0d, want T=0 Qs=10", i, Tick1Hz, Qs);
            end
        end
        StartStop = 1'b1;
        step();
        n_cmp++;
        if (Running !== 1'b1) begin
            n_err++;
            $display("FAIL resume: got R=%b, want 1", Running);
        end
        for (int i = 1; i <= 9; i++) begin
            step();
            if (i == 1 || i == 2) begin
                n_cmp++;
                if (Tick1Hz !== (i == 2) || Qs !== ((i == 2) ? 6'd9 : 6'd10)) begin
                    n_err++;
                    $display("FAIL resume_tick cyc%0d: got T=%b Qs=%0d, want T=%b", i, Tick1Hz, Qs, (i == 2));
                end
            end
            n_cmp++;
            if (Running !== 1'b1) begin
                n_err++;
                $display("FAIL held_ss cyc%0d: got R=%b, want 1", i, Running);
            end
        end
        StartStop = 1'b0;
        n_cmp++;
        if (Qs !== 6'd8) begin
            n_err++;
            $display("FAIL held_ss_count: got Qs=%0d, want 8", Qs);
        end
    endtask

    task automatic test_clear_load_priority();
        do_clear();
        do_load(2'd0, 6'd10);
        press();
        step();
        press();
        PresetM = 2'd2;
        PresetS = 6'd30;
        Clear = 1'b1;
        Load = 1'b1;
        step();
        Clear = 1'b0;
        Load = 1'b0;
        n_cmp++;
        if ({Qm, Qs, Running, Done} !== 10'd0) begin
            n_err++;
            $display("FAIL clear_over_load: got %0d:%0d R=%b D=%b, want 0:0 idle", Qm, Qs, Running, Done);
        end
        do_load(2'd0, 6'd5);
        press();
        PresetM = 2'd3;
        PresetS = 6'd40;
        Load = 1'b1;
        repeat (2) step();
        Load = 1'b0;
        n_cmp++;
        if (Qm !== 2'd0 || Qs !== 6'd5 || Running !== 1'b1) begin
            n_err++;
            $display("FAIL load_in_run: got %0d:%0d R=%b, want 0:5 R=1", Qm, Qs, Running);
        end
    endtask

    task automatic test_zero_start();
        do_clear();
        press();
        n_cmp++;
        if (Done !== 1'b1 || Running !== 1'b0) begin
            n_err++;
            $display("FAIL zero_start: got D=%b R=%b, want D=1 R=0", Done, Running);
        end
        do_load(2'd3, 6'd59);
        n_cmp++;
        if (Qm !== 2'd3 || Qs !== 6'd59 || Done !== 1'b0 || Running !== 1'b0) begin
            n_err++;
            $display("FAIL done_load: got %0d:%0d D=%b R=%b, want 3:59 D=0 R=0", Qm, Qs, Done, Running);
        end
    endtask

    initial begin
        test_reset();
        test_countdown_done();
        test_minute_borrow();
        test_pause_resume();
        test_clear_load_priority();
        test_zero_start();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
